// File: rtl/polybius_pkg.sv
// Shared types, constants and symbol helpers for the keyed 5x5 Polybius cipher.
package polybius_pkg;

  localparam int SQ_N    = 5;
  localparam int SQ_SIZE = 25;
  localparam int ALPHA_N = 26;

  typedef enum logic [1:0] {KEY_LOAD, BUILD, READY} state_t;
  typedef enum logic {ENCRYPT = 1'b0, DECRYPT = 1'b1} mode_t;

  typedef logic [4:0] letter_idx_t;  // A=0 .. Z=25
  typedef logic [4:0] sq_pos_t;      // row-major square position 0..24

  localparam letter_idx_t IDX_I       = 5'd8;
  localparam letter_idx_t IDX_J       = 5'd9;
  localparam letter_idx_t LETTER_NONE = 5'd31;

  // Fold lower case to upper case and J onto I; anything else is LETTER_NONE.
  function automatic letter_idx_t to_idx(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
    if (u < 8'h41 || u > 8'h5A) return LETTER_NONE;
    if (u == 8'h4A) return IDX_I;
    return letter_idx_t'(u - 8'h41);
  endfunction

  // A code is valid only when both decimal digits are in 1..SQ_N.
  function automatic logic code_ok(input logic [7:0] c);
    logic [7:0] tens;
    logic [7:0] units;
    tens  = c / 8'd10;
    units = c % 8'd10;
    return tens >= 8'd1 && tens <= 8'(SQ_N) && units >= 8'd1 && units <= 8'(SQ_N);
  endfunction

  function automatic sq_pos_t code_to_pos(input logic [7:0] c);
    logic [7:0] p;
    p = (c / 8'd10 - 8'd1) * 8'(SQ_N) + (c % 8'd10) - 8'd1;
    return sq_pos_t'(p);
  endfunction

  function automatic logic [7:0] pos_to_code(input sq_pos_t pos);
    logic [7:0] p;
    p = {3'b000, pos};
    return (p / 8'(SQ_N) + 8'd1) * 8'd10 + p % 8'(SQ_N) + 8'd1;
  endfunction

endpackage

// File: rtl/polybius_stream_cipher_if.sv
// Key stream, message input and result output handshakes of the Polybius cipher.
interface polybius_stream_cipher_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_data;
  logic       key_last;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output key_valid, key_data, key_last, in_valid, in_data, in_last, out_ready,
    input  key_ready, in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  key_valid, key_data, key_last, in_valid, in_data, in_last, out_ready,
    output key_ready, in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/polybius_square.sv
// Keyed square store: square table, letter->position inverse table, used bitmap,
// fill pointer and the alphabet build sequencer.
module polybius_square
  import polybius_pkg::*;
#(
  parameter int KEY_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        key_we,
  input  letter_idx_t key_idx,
  input  logic        build_en,
  output logic        done,
  input  letter_idx_t enc_idx,
  output sq_pos_t     enc_pos,
  input  sq_pos_t     dec_pos,
  output letter_idx_t dec_idx
);

  localparam logic [4:0] KEY_LIM = 5'(KEY_MAX);

  letter_idx_t        square [SQ_SIZE];
  sq_pos_t            inv    [ALPHA_N];
  logic [ALPHA_N-1:0] used;
  logic [4:0]         fill_ptr;
  logic [4:0]         build_idx;
  logic               wr_en;
  letter_idx_t        wr_idx;

  // NOTE: defaults come first so every path assigns wr_en/wr_idx; a missing default infers a latch.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = key_idx;
    if (key_we) begin
      wr_en = key_idx != LETTER_NONE && !used[key_idx] && fill_ptr < KEY_LIM;
    end else if (build_en && build_idx < 5'(ALPHA_N)) begin
      wr_idx = build_idx;
      wr_en  = build_idx != IDX_J && !used[build_idx] && fill_ptr != 5'(SQ_SIZE);
    end
  end

  // Counting the write in flight lets BUILD finish on the cycle that places the 25th letter.
  assign done = fill_ptr == 5'(SQ_SIZE) || (wr_en && fill_ptr == 5'(SQ_SIZE - 1));

  // NOTE: non-blocking (<=) for all state so every flop samples pre-edge values.
  // NOTE: the tables are flops, not RAM, so they clear in one cycle on reset and rekey.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      used      <= '0;
      fill_ptr  <= '0;
      build_idx <= '0;
      for (int i = 0; i < SQ_SIZE; i++) square[i] <= '0;
      for (int i = 0; i < ALPHA_N; i++) inv[i] <= '0;
    end else if (clear) begin
      used      <= '0;
      fill_ptr  <= '0;
      build_idx <= '0;
      for (int i = 0; i < SQ_SIZE; i++) square[i] <= '0;
      for (int i = 0; i < ALPHA_N; i++) inv[i] <= '0;
    end else begin
      if (build_en && build_idx < 5'(ALPHA_N)) build_idx <= build_idx + 5'd1;
      if (wr_en) begin
        square[fill_ptr] <= wr_idx;
        inv[wr_idx]      <= fill_ptr;
        used[wr_idx]     <= 1'b1;
        fill_ptr         <= fill_ptr + 5'd1;
      end
    end
  end

  assign enc_pos = (enc_idx < 5'(ALPHA_N)) ? inv[enc_idx] : '0;
  assign dec_idx = (dec_pos < 5'(SQ_SIZE)) ? square[dec_pos] : '0;

endmodule

// File: rtl/polybius_stream_cipher.sv
// Byte-serial keyed Polybius encrypt/decrypt engine: FSM, handshakes, output register.
// Define POLY_ERR_CNT_EN to add the saturating invalid-symbol counter err_cnt.
module polybius_stream_cipher
  import polybius_pkg::*;
#(
  parameter int KEY_MAX = 16
`ifdef POLY_ERR_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  polybius_stream_cipher_if.slave   bus,
  input  logic                      rekey,
  input  logic                      mode,
  output logic                      sq_ready
`ifdef POLY_ERR_CNT_EN
  , output logic [CNT_W-1:0]        err_cnt
`endif
);

  state_t      state, state_nxt;
  logic        in_flight, in_flight_nxt;
  logic        rekey_pend, rekey_req;
  mode_t       mode_q, cur_mode;
  logic        key_fire, in_fire;
  logic        sq_clear, sq_build, sq_done;
  letter_idx_t in_idx, dec_idx;
  sq_pos_t     enc_pos;
  logic [7:0]  result;

  assign key_fire      = bus.key_valid && bus.key_ready && !rekey;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign in_flight_nxt = in_fire ? !bus.in_last : in_flight;
  assign rekey_req     = rekey || rekey_pend;
  assign cur_mode      = in_flight ? mode_q : mode_t'(mode);
  assign in_idx        = to_idx(bus.in_data);

  polybius_square #(.KEY_MAX(KEY_MAX)) u_square (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (sq_clear),
    .key_we   (key_fire),
    .key_idx  (to_idx(bus.key_data)),
    .build_en (sq_build),
    .done     (sq_done),
    .enc_idx  (in_idx),
    .enc_pos  (enc_pos),
    .dec_pos  (code_to_pos(bus.in_data)),
    .dec_idx  (dec_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= KEY_LOAD;
    else        state <= state_nxt;
  end

  // A rekey in READY waits until no message is in flight after this cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      KEY_LOAD: if (key_fire && bus.key_last) state_nxt = BUILD;
      BUILD:    if (rekey) state_nxt = KEY_LOAD;
                else if (sq_done) state_nxt = READY;
      READY:    if (rekey_req && !in_flight_nxt) state_nxt = KEY_LOAD;
      default:  state_nxt = KEY_LOAD;
    endcase
  end

  always_comb begin
    bus.key_ready = state == KEY_LOAD;
    sq_ready      = state == READY;
    bus.in_ready  = state == READY && (!bus.out_valid || bus.out_ready);
    sq_build      = state == BUILD && !rekey;
    sq_clear      = (rekey && state != READY) || (state == READY && state_nxt == KEY_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight  <= 1'b0;
      rekey_pend <= 1'b0;
      mode_q     <= ENCRYPT;
    end else begin
      in_flight  <= in_flight_nxt;
      rekey_pend <= state == READY && rekey_req && in_flight_nxt;
      if (in_fire) mode_q <= cur_mode;
    end
  end

  always_comb begin
    result = 8'd0;
    if (cur_mode == DECRYPT) begin
      if (code_ok(bus.in_data)) result = 8'h41 + {3'b000, dec_idx};
    end else if (in_idx != LETTER_NONE) begin
      result = pos_to_code(enc_pos);
    end
  end

  // Output register holds its beat until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= 8'd0;
      bus.out_last  <= 1'b0;
    end else if (in_fire) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= result;
      bus.out_last  <= bus.in_last;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef POLY_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else if (in_fire && result == 8'd0 && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_polybius_stream_cipher.sv
// Directed scoreboard bench for polybius_stream_cipher (default and KEY_MAX=4 instances).
`timescale 1ns/1ps
module tb_polybius_stream_cipher;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rekey = 1'b0, mode = 1'b0, sq_ready;
  logic rekey2 = 1'b0, mode2 = 1'b0, sq_ready2;
  int   n_checks = 0;
  int   n_errors = 0;
  int   bc;
  exp_t sb[$];
`ifdef POLY_ERR_CNT_EN
  logic [15:0] err_cnt, err_cnt2;
`endif

  always #5 clk = ~clk;

  polybius_stream_cipher_if m ();
  polybius_stream_cipher_if m2 ();

  polybius_stream_cipher dut (
    .clk(clk), .rst_n(rst_n), .bus(m), .rekey(rekey), .mode(mode), .sq_ready(sq_ready)
`ifdef POLY_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  polybius_stream_cipher #(.KEY_MAX(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(m2), .rekey(rekey2), .mode(mode2), .sq_ready(sq_ready2)
`ifdef POLY_ERR_CNT_EN
    , .err_cnt(err_cnt2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && m.out_valid && m.out_ready) begin
      n_checks++;
      assert (sb.size() > 0) else begin
        n_errors++;
        $error("FAIL out_spurious: observed data %0d expected no output", m.out_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_data", m.out_data, e.data);
        check("out_last", m.out_last, e.last);
      end
    end
  end

  task automatic key_byte(input bit which, input logic [7:0] d, input bit l);
    int t = 0;
    if (!which) begin m.key_valid = 1'b1; m.key_data = d; m.key_last = l; end
    else begin m2.key_valid = 1'b1; m2.key_data = d; m2.key_last = l; end
    @(negedge clk);
    while (!(which ? m2.key_ready : m.key_ready) && t < 100) begin @(negedge clk); t++; end
    check("key_ready_wait", which ? m2.key_ready : m.key_ready, 1);
    @(posedge clk); #1;
    m.key_valid = 1'b0;
    m2.key_valid = 1'b0;
  endtask

  task automatic load_key(input string s);
    for (int i = 0; i < s.len(); i++) key_byte(1'b0, s[i], i == s.len() - 1);
  endtask

  task automatic wait_sq(input bit which, output int n);
    n = 0;
    @(negedge clk);
    while (!(which ? sq_ready2 : sq_ready) && n < 60) begin n++; @(negedge clk); end
    check("sq_ready_wait", which ? sq_ready2 : sq_ready, 1);
    check("build_le_26", n <= 26, 1);
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [7:0] e);
    int t = 0;
    sb.push_back('{data: e, last: l});
    m.in_valid = 1'b1; m.in_data = d; m.in_last = l;
    @(negedge clk);
    while (!m.in_ready && t < 100) begin @(negedge clk); t++; end
    check("in_ready_wait", m.in_ready, 1);
    @(posedge clk); #1;
    m.in_valid = 1'b0;
  endtask

  // Byte i of an n-byte vector sits at bits [8*(n-1-i) +: 8]; term marks last on the final byte.
  task automatic send_vec(input int n, input logic [47:0] din, input logic [47:0] dexp, input bit term);
    for (int i = 0; i < n; i++)
      send(din[8*(n-1-i) +: 8], term && i == n - 1, dexp[8*(n-1-i) +: 8]);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rekey();
    rekey = 1'b1;
    @(posedge clk); #1;
    rekey = 1'b0;
  endtask

  task automatic enc2(input logic [7:0] d, input logic [7:0] e);
    int t = 0;
    m2.in_valid = 1'b1; m2.in_data = d; m2.in_last = 1'b1;
    @(negedge clk);
    while (!m2.in_ready && t < 100) begin @(negedge clk); t++; end
    check("in_ready2_wait", m2.in_ready, 1);
    @(posedge clk); #1;
    m2.in_valid = 1'b0;
    @(negedge clk);
    check("dut2_out_valid", m2.out_valid, 1);
    check("dut2_out_data", m2.out_data, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    m.key_valid = 0; m.key_data = 0; m.key_last = 0;
    m.in_valid = 0; m.in_data = 0; m.in_last = 0; m.out_ready = 1;
    m2.key_valid = 0; m2.key_data = 0; m2.key_last = 0;
    m2.in_valid = 0; m2.in_data = 0; m2.in_last = 0; m2.out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_key_ready", m.key_ready, 1);
    check("rst_sq_ready", sq_ready, 0);
    check("rst_in_ready", m.in_ready, 0);
    check("rst_out_valid", m.out_valid, 0);
    check("rst_out_data", m.out_data, 0);
    check("rst_out_last", m.out_last, 0);
    check("rst_key_ready2", m2.key_ready, 1);
`ifdef POLY_ERR_CNT_EN
    check("rst_err_cnt", err_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Key SECRET, encrypt HELLOW
    load_key("SECRET");
    wait_sq(1'b0, bc);
    @(posedge clk); #1;
    send_vec(6, "HELLOW", {8'd31, 8'd12, 8'd34, 8'd34, 8'd42, 8'd52}, 1'b1);
    drain();

    // Output stall mid-message
    send_vec(2, "HE", {8'd31, 8'd12}, 1'b0);
    m.out_ready = 1'b0;
    m.in_valid = 1'b1; m.in_data = "L"; m.in_last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_out_data", m.out_data, 8'd12);
      check("stall_out_valid", m.out_valid, 1);
      check("stall_in_ready", m.in_ready, 0);
    end
    @(posedge clk); #1;
    m.out_ready = 1'b1;
    send_vec(3, "LLO", {8'd34, 8'd34, 8'd42}, 1'b1);
    drain();

    // Deferred rekey and ignored mid-message mode change
    send_vec(2, "WO", {8'd52, 8'd42}, 1'b0);
    pulse_rekey();
    mode = 1'b1;
    @(negedge clk);
    check("rekey_deferred_sq", sq_ready, 1);
    check("rekey_deferred_key", m.key_ready, 0);
    @(posedge clk); #1;
    send_vec(3, "RLD", {8'd14, 8'd34, 8'd23}, 1'b1);
    @(negedge clk);
    check("rekey_done_key", m.key_ready, 1);
    check("rekey_done_sq", sq_ready, 0);
    drain();
    mode = 1'b0;

    // Empty key: standard square
    key_byte(1'b0, 8'h00, 1'b1);
    wait_sq(1'b0, bc);
    @(posedge clk); #1;
    send_vec(5, "hello", {8'd23, 8'd15, 8'd31, 8'd31, 8'd34}, 1'b1);
    mode = 1'b1;
    send_vec(5, {8'd23, 8'd15, 8'd31, 8'd31, 8'd34}, "HELLO", 1'b1);
    mode = 1'b0;
    send_vec(1, "J", 48'd24, 1'b1);
    drain();

    // Invalid symbols
    mode = 1'b1;
    send_vec(3, {8'd66, 8'd10, 8'hFF}, 48'd0, 1'b1);
    drain();
`ifdef POLY_ERR_CNT_EN
    check("err_cnt_3", err_cnt, 3);
`endif
    mode = 1'b0;
    send_vec(2, "H1", {8'd23, 8'd0}, 1'b1);
    drain();
`ifdef POLY_ERR_CNT_EN
    check("err_cnt_4", err_cnt, 4);
`endif

    // Idle rekey, then rekey beats a simultaneous key byte
    pulse_rekey();
    @(negedge clk);
    check("idle_rekey_key_ready", m.key_ready, 1);
    @(posedge clk); #1;
    m.key_valid = 1'b1; m.key_data = "Z"; m.key_last = 1'b1; rekey = 1'b1;
    @(posedge clk); #1;
    m.key_valid = 1'b0; rekey = 1'b0;
    @(negedge clk);
    check("rekey_wins_key_ready", m.key_ready, 1);
    @(posedge clk); #1;
    key_byte(1'b0, 8'h00, 1'b1);
    wait_sq(1'b0, bc);
    @(posedge clk); #1;
    send_vec(1, "A", 48'd11, 1'b1);
    drain();

    // KEY_MAX=4 instance: 30 key bytes Z,Y,X,... only Z Y X W used
    for (int i = 0; i < 30; i++) begin
      logic [7:0] d;
      d = 8'd90 - 8'(i % 26);
      key_byte(1'b1, d, i == 29);
    end
    wait_sq(1'b1, bc);
    @(posedge clk); #1;
    enc2("A", 8'd15);
    enc2("V", 8'd55);
    enc2("Z", 8'd11);

    // Reset during BUILD
    @(posedge clk); #1;
    rekey2 = 1'b1;
    @(posedge clk); #1;
    rekey2 = 1'b0;
    key_byte(1'b1, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_build_sq2", sq_ready2, 0);
    check("mid_build_key2", m2.key_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("build_rst_sq2", sq_ready2, 0);
    check("build_rst_key2", m2.key_ready, 1);
    check("build_rst_sq", sq_ready, 0);
    check("build_rst_key", m.key_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
